// File: rtl/pfpq_multiport_reorder_queue.sv
// In-order retirement queue for multi-cycle FP ops with NUM_RES_PORTS completion channels.
// Optional head bypass (result straight to fin_* in the same cycle): define PFPQ_HEAD_BYPASS_EN.
module pfpq_multiport_reorder_queue #(
  parameter int DEPTH         = 8,
  parameter int NUM_RES_PORTS = 2,
  parameter int INSTR_W       = 128,
  parameter int DATA_W        = 64,
  parameter int STATUS_W      = 5,
  localparam int TAG_W        = $clog2(DEPTH) + 1
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic                              flush_i,
  input  logic                              alloc_valid_i,
  input  logic [INSTR_W-1:0]                alloc_instr_i,
  output logic                              alloc_ready_o,
  output logic [TAG_W-1:0]                  alloc_tag_o,
  input  logic [NUM_RES_PORTS-1:0]          res_valid_i,
  input  logic [NUM_RES_PORTS*TAG_W-1:0]    res_tag_i,
  input  logic [NUM_RES_PORTS*DATA_W-1:0]   res_data_i,
  input  logic [NUM_RES_PORTS*STATUS_W-1:0] res_status_i,
  output logic                              fin_valid_o,
  input  logic                              fin_ready_i,
  output logic [INSTR_W-1:0]                fin_instr_o,
  output logic [DATA_W-1:0]                 fin_data_o,
  output logic [STATUS_W-1:0]               fin_status_o,
  output logic [$clog2(DEPTH):0]            count_o,
  output logic                              stale_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DEPTH-1:0]    valid_q, done_q, wrap_q;
  logic [INSTR_W-1:0]  instr_q  [DEPTH];
  logic [DATA_W-1:0]   data_q   [DEPTH];
  logic [STATUS_W-1:0] status_q [DEPTH];
  logic [TAG_W-1:0]    head_q, tail_q;
  logic [CNT_W-1:0]    count_q;
  logic                stale_q;

  logic [IDX_W-1:0]         res_idx    [NUM_RES_PORTS];
  logic [DATA_W-1:0]        res_data   [NUM_RES_PORTS];
  logic [STATUS_W-1:0]      res_status [NUM_RES_PORTS];
  logic [NUM_RES_PORTS-1:0] res_wrap, res_hit, res_acc;

  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             alloc_fire, retire_fire, stored_valid;
  logic             byp_valid;
  logic [DATA_W-1:0]   byp_data;
  logic [STATUS_W-1:0] byp_status;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  always_comb begin
    for (int p = 0; p < NUM_RES_PORTS; p++) begin
      res_idx[p]    = res_tag_i[p*TAG_W +: IDX_W];
      res_wrap[p]   = res_tag_i[p*TAG_W + IDX_W];
      res_data[p]   = res_data_i[p*DATA_W +: DATA_W];
      res_status[p] = res_status_i[p*STATUS_W +: STATUS_W];
      res_hit[p]    = res_valid_i[p] && valid_q[res_idx[p]] && !done_q[res_idx[p]] &&
                      (wrap_q[res_idx[p]] == res_wrap[p]);
    end
  end

  // Lowest-numbered accepted port owns an entry; later ports aimed at it are dropped.
  always_comb begin
    logic [NUM_RES_PORTS-1:0] acc;
    acc = '0;
    for (int p = 0; p < NUM_RES_PORTS; p++) begin
      acc[p] = res_hit[p];
      for (int q = 0; q < NUM_RES_PORTS; q++) begin
        if (q < p && acc[q] && res_idx[q] == res_idx[p]) acc[p] = 1'b0;
      end
    end
    res_acc = acc;
  end

`ifdef PFPQ_HEAD_BYPASS_EN
  always_comb begin
    byp_valid  = 1'b0;
    byp_data   = '0;
    byp_status = '0;
    for (int p = NUM_RES_PORTS - 1; p >= 0; p--) begin
      if (rstn_i && !flush_i && res_acc[p] && res_idx[p] == head_idx) begin
        byp_valid  = 1'b1;
        byp_data   = res_data[p];
        byp_status = res_status[p];
      end
    end
  end
`else
  assign byp_valid  = 1'b0;
  assign byp_data   = '0;
  assign byp_status = '0;
`endif

  assign stored_valid  = valid_q[head_idx] && done_q[head_idx];
  assign fin_valid_o   = stored_valid || byp_valid;
  assign fin_instr_o   = fin_valid_o ? instr_q[head_idx] : '0;
  assign fin_data_o    = !fin_valid_o ? '0 : (stored_valid ? data_q[head_idx] : byp_data);
  assign fin_status_o  = !fin_valid_o ? '0 : (stored_valid ? status_q[head_idx] : byp_status);

  assign alloc_ready_o = (count_q < DEPTH_C) && !flush_i && rstn_i;
  assign alloc_tag_o   = tail_q;
  assign count_o       = count_q;
  assign stale_o       = stale_q;

  assign alloc_fire  = alloc_valid_i && alloc_ready_o;
  assign retire_fire = fin_valid_o && fin_ready_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      valid_q <= '0;
      done_q  <= '0;
      wrap_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stale_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i]  <= '0;
        data_q[i]   <= '0;
        status_q[i] <= '0;
      end
    end else if (flush_i) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stale_q <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_RES_PORTS; p++) begin
        if (res_acc[p]) begin
          done_q[res_idx[p]]   <= 1'b1;
          data_q[res_idx[p]]   <= res_data[p];
          status_q[res_idx[p]] <= res_status[p];
        end
      end
      if (alloc_fire) begin
        valid_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
        wrap_q[tail_idx]  <= tail_q[TAG_W-1];
        instr_q[tail_idx] <= alloc_instr_i;
        tail_q            <= tail_q + 1'b1;
      end
      if (retire_fire) begin
        valid_q[head_idx] <= 1'b0;
        head_q            <= head_q + 1'b1;
      end
      stale_q <= |(res_valid_i & ~res_acc);
      case ({alloc_fire, retire_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: doc/pfpq_multiport_reorder_queue.md
# pfpq_multiport_reorder_queue

Parametrised in-order retirement queue for multi-cycle FP operations in the execute stage. It accepts issued FP instructions, hands each one a tag, and collects out-of-order results from up to NUM_RES_PORTS completion channels. It presents completed entries strictly in program order to writeback over a valid/ready handshake. Successor to the single-port pending FP queue: depth, widths and completion-port count are all configurable, and retirement uses backpressure instead of a blind advance.

## Interface
Parameters:
- DEPTH, 8: entries; power of two, at least 2.
- NUM_RES_PORTS, 2: completion channels, 1 to 4.
- INSTR_W, 128: opaque instruction payload width.
- DATA_W, 64: result data width.
- STATUS_W, 5: FP exception flags width.
- TAG_W, $clog2(DEPTH)+1: derived, not overridable. Low bits are the entry index; MSB is the wrap (generation) bit.

Ports:
- clk_i, in, 1: clock.
- rstn_i, in, 1: synchronous active-low reset.
- flush_i, in, 1: discard all entries.
- alloc_valid_i, in, 1: instruction offered.
- alloc_instr_i, in, INSTR_W: instruction payload.
- alloc_ready_o, out, 1: queue can accept.
- alloc_tag_o, out, TAG_W: tag the offered instruction receives; equals the tail pointer.
- res_valid_i, in, NUM_RES_PORTS: one result-valid bit per channel.
- res_tag_i, in, NUM_RES_PORTS*TAG_W: result tags, packed, with port 0 in the LSBs.
- res_data_i, in, NUM_RES_PORTS*DATA_W: result data, packed.
- res_status_i, in, NUM_RES_PORTS*STATUS_W: FP flags, packed.
- fin_valid_o, out, 1: head entry is complete.
- fin_ready_i, in, 1: writeback accepts the head entry.
- fin_instr_o, out, INSTR_W: head payload.
- fin_data_o, out, DATA_W: head result.
- fin_status_o, out, STATUS_W: head flags.
- count_o, out, $clog2(DEPTH)+1: occupied entries.
- stale_o, out, 1: pulses for one cycle when any valid result is dropped.

## Operation
Per-entry state: valid, done, wrap, instr, data, status. Pointers: head and tail, each TAG_W wide with the wrap bit as MSB. Counter: count.

Allocation:
- An allocation occurs when alloc_valid_i && alloc_ready_o.
- The entry at tail[idx] is written with valid=1, done=0, wrap=tail MSB and instr=payload; then tail increments modulo 2*DEPTH.
- alloc_ready_o = (count < DEPTH) && !flush_i && rstn_i. It does not depend on fin_ready_i, so a full queue refuses allocation even in a cycle where it retires.

Completion, per port p with res_valid_i[p] set:
- Entry e = res_tag_i[p] low bits.
- The result is accepted only if valid[e], !done[e] and wrap[e] == tag MSB. On acceptance, done=1 and data/status are captured.
- Otherwise the result is dropped and stale_o=1 the next cycle.
- If several ports hit the same entry in one cycle, the lowest-numbered port wins; the others count as dropped.
- Results that target an entry being allocated in the same cycle are dropped, because that entry is not yet valid.

Retirement:
- fin_valid_o = valid[head] && done[head].
- A retirement occurs when fin_valid_o && fin_ready_i. It clears valid[head] and increments head.
- When fin_valid_o=0, fin_instr_o, fin_data_o and fin_status_o are all zero.

Count:
- count += alloc − retire.
- Simultaneous allocation and retirement leaves count unchanged.

Flush (flush_i=1):
- All valid and done bits clear; head, tail and count go to 0. Payload registers are not cleared.
- Allocation, completion and retirement are all ignored in that cycle. stale_o is not raised for results ignored during flush.

Reset (rstn_i=0):
- Same effect as flush, and payload, data and status registers are also zeroed.
- Reset takes priority over flush.
- Reset asserted mid-operation discards all entries at the next edge.

## Timing
- Reset values: alloc_ready_o=0 while rstn_i=0, then 1 after release; alloc_tag_o=0; fin_valid_o=0; all fin_* data outputs 0; count_o=0; stale_o=0.
- Allocation accepted at edge N: the entry is visible and count_o updates after edge N.
- Result accepted at edge N, entry at head: fin_valid_o=1 in cycle N+1. Without bypass, minimum result-to-retire latency is 1 cycle.
- fin_* outputs are combinational from registered state; the only combinational input-to-output path is through bypass.
- With fin_ready_i=0, fin_* outputs hold stable until the entry retires.
- Pointer wrap: after 2*DEPTH allocations tail returns to 0. A stale tag from the previous generation fails the wrap check.

## Configuration
- Macro: PFPQ_HEAD_BYPASS_EN.
- Defined: when the head entry is valid and not done, and an accepted result (lowest winning port) targets it in the same cycle, fin_valid_o=1 combinationally that cycle. fin_data_o/fin_status_o come from the result port and fin_instr_o from storage. If fin_ready_i=1 the entry retires at that edge, giving zero-cycle latency.
- Not defined: no combinational path from res_* to fin_*; latency as in Timing.

## Test plan
- Fill: DEPTH=8, 8 allocations with fin_ready_i=1 and no results -> tags 0..7, alloc_ready_o=0 on cycle 9, count_o=8. A 9th alloc_valid_i is not accepted.
- Out-of-order completion: alloc tags 0,1,2; complete 2 with data 0xC, then 0 with 0xA, then 1 with 0xB -> fin_data_o sequence 0xA, 0xB, 0xC, in tag order only.
- Same-cycle port conflict: ports 0 and 1 both complete tag 3 with 0x11 and 0x22 -> 0x11 stored; stale_o=1 for one cycle.
- Wrap/stale: cycle through 10 entries, then send tag 0x1 (old generation) while entry 1 holds wrap=1 -> dropped, stale_o=1, entry stays not done.
- Backpressure and flush: head complete with fin_ready_i=0 for 5 cycles -> outputs stable. Then flush_i with 3 entries -> count_o=0, fin_valid_o=0, and the next alloc_tag_o=0.
- Bypass (macro defined): result for head tag with fin_ready_i=1 -> fin_valid_o=1 in the same cycle, and count_o decrements at that edge.
